// File: rtl/frame_input_sequencer_if.sv
`default_nettype none
// ==== frame_input_sequencer_if : host pixel stream and result return channel (rev 1.0) ====

interface frame_input_sequencer_if #(
    parameter int PIX_BITS = 8
);
    logic                s_valid;
    logic                s_ready;
    logic [PIX_BITS-1:0] s_data;
    logic                s_last;
    logic                res_valid;
    logic [3:0]          res_decision;
    logic                res_timeout;
    logic                frame_err;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, res_valid, res_decision, res_timeout, frame_err
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, res_valid, res_decision, res_timeout, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/frame_input_sequencer.sv
`default_nettype none
// ==== frame_input_sequencer : ping-pong frame buffer that sequences the CNN core per frame (rev 1.0) ====

module frame_input_sequencer #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int PIX_BITS = 8,
    parameter int WB_WAIT  = 2,
    parameter int RST_CYC  = 4,
    parameter int TIMEOUT  = 4096
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    frame_input_sequencer_if.slave   host,
    output logic [PIX_BITS-1:0]      pix_out,
    output logic                     pix_valid,
    output logic                     core_rst_n,
    output logic                     wb_load,
    input  wire logic                core_valid,
    input  wire logic [3:0]          core_decision,
    output logic                     busy
);

    localparam int N    = IMG_W * IMG_H;
    localparam int AW   = $clog2(N);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int CMAX = (WB_WAIT > RST_CYC) ? WB_WAIT : RST_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RELEASE, S_LOADWB, S_WBWAIT, S_STREAM, S_DRAIN, S_RECOVER
    } state_t;

    state_t state, next_state;

    logic [PIX_BITS-1:0] bank0 [0:N-1];
    logic [PIX_BITS-1:0] bank1 [0:N-1];

    logic [1:0]          full;
    logic                wbank, rbank;
    logic [AW-1:0]       wcnt, rcnt, rd_addr;
    logic [CW-1:0]       cnt;
    logic [TW-1:0]       tcnt;
    logic                accept, wr_at_end, wr_done, wr_bad;
    logic                rd_load, rd_done, res_fire, res_to;
    logic [PIX_BITS-1:0] rd_data;
    logic                frame_err_q, res_valid_q, res_timeout_q;
    logic [3:0]          res_decision_q;

    // Ready is forced low while reset is held so the host sees the reset value immediately.
    assign host.s_ready      = rst_n && !full[wbank];
    assign host.frame_err    = frame_err_q;
    assign host.res_valid    = res_valid_q;
    assign host.res_decision = res_decision_q;
    assign host.res_timeout  = res_timeout_q;

    assign accept    = host.s_valid && host.s_ready;
    assign wr_at_end = (wcnt == LAST_IDX);
    assign wr_done   = accept && wr_at_end && host.s_last;
    assign wr_bad    = accept && (wr_at_end != host.s_last);

    always_ff @(posedge clk) begin
        if (accept && !wbank) bank0[wcnt] <= host.s_data;
        if (accept &&  wbank) bank1[wcnt] <= host.s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank       <= 1'b0;
            wcnt        <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= wr_bad;
            if (accept) begin
                if (wr_done) begin
                    wbank <= !wbank;
                    wcnt  <= '0;
                end else if (wr_bad) begin
                    wcnt  <= '0;
                end else begin
                    wcnt  <= wcnt + AW'(1);
                end
            end
        end
    end

    // The writer is blocked on full, so set and clear never target the same bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (wr_done) full[wbank] <= 1'b1;
            if (rd_done) full[rbank] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RECOVER;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        core_rst_n = 1'b0;
        wb_load    = 1'b0;
        pix_valid  = 1'b0;
        busy       = 1'b1;
        rd_load    = 1'b0;
        rd_done    = 1'b0;
        res_fire   = 1'b0;
        res_to     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (full[rbank]) next_state = S_RELEASE;
            end
            S_RELEASE: begin
                core_rst_n = 1'b1;
                next_state = S_LOADWB;
            end
            S_LOADWB: begin
                core_rst_n = 1'b1;
                wb_load    = 1'b1;
                next_state = S_WBWAIT;
            end
            S_WBWAIT: begin
                core_rst_n = 1'b1;
                if (cnt == CW'(1)) begin
                    rd_load    = 1'b1;
                    next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                core_rst_n = 1'b1;
                pix_valid  = 1'b1;
                if (rcnt == LAST_IDX) begin
                    rd_done    = 1'b1;
                    next_state = S_DRAIN;
                end else begin
                    rd_load    = 1'b1;
                end
            end
            S_DRAIN: begin
                core_rst_n = 1'b1;
                if (core_valid) begin
                    res_fire   = 1'b1;
                    next_state = S_RECOVER;
                end else if (tcnt == TW'(1)) begin
                    res_fire   = 1'b1;
                    res_to     = 1'b1;
                    next_state = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (cnt == CW'(1)) next_state = S_IDLE;
            end
            default: next_state = S_RECOVER;
        endcase
    end

    // Prefetch: the address one ahead of the pixel on pix_out keeps the stream gap-free.
    always_comb begin
        rd_addr = '0;
        if (state == S_STREAM && rcnt != LAST_IDX) rd_addr = rcnt + AW'(1);
    end

    assign rd_data = rbank ? bank1[rd_addr] : bank0[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= CW'(RST_CYC);
            rcnt           <= '0;
            tcnt           <= '0;
            rbank          <= 1'b0;
            pix_out        <= '0;
            res_valid_q    <= 1'b0;
            res_decision_q <= 4'h0;
            res_timeout_q  <= 1'b0;
        end else begin
            res_valid_q <= res_fire;
            if (res_fire) begin
                res_decision_q <= res_to ? 4'hF : core_decision;
                res_timeout_q  <= res_to;
            end
            pix_out <= rd_load ? rd_data : '0;
            case (state)
                S_LOADWB: cnt <= CW'(WB_WAIT);
                S_WBWAIT: begin
                    cnt  <= cnt - CW'(1);
                    rcnt <= '0;
                end
                S_STREAM: begin
                    if (rd_done) begin
                        rbank <= !rbank;
                        tcnt  <= TW'(TIMEOUT);
                    end else begin
                        rcnt  <= rcnt + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (res_fire) cnt  <= CW'(RST_CYC);
                    else          tcnt <= tcnt - TW'(1);
                end
                S_RECOVER: cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/frame_input_sequencer.md
Name: frame_input_sequencer

Overview:
- Upstream feeder for the ternary CNN core. Accepts 28x28 8-bit images from a host over a valid/ready stream into a ping-pong frame buffer.
- Per frame, it sequences the core: releases core reset, pulses the conv2 weight-bank load, then streams pixels contiguously, one per cycle, in raster order.
- It captures the 4-bit decision from the comparator and returns it to the host with a timeout guard.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- PIX_BITS, 8, pixel width
- WB_WAIT, 2, cycles between wb_load pulse and first pixel (min 1)
- RST_CYC, 4, cycles core_rst_n is held low after each frame (min 1)
- TIMEOUT, 4096, max cycles from last streamed pixel to core result

Ports:
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  host pixel valid
- s_ready  out  1  host pixel ready
- s_data  in  PIX_BITS  host pixel
- s_last  in  1  marks final pixel of a frame
- pix_out  out  PIX_BITS  pixel to core data_in
- pix_valid  out  1  high exactly while streaming pixels
- core_rst_n  out  1  core reset, active-low
- wb_load  out  1  one-cycle weight-bank load pulse to core
- core_valid  in  1  core result valid (comparator valid_out)
- core_decision  in  4  core class decision
- res_valid  out  1  one-cycle result pulse to host
- res_decision  out  4  captured decision, held until next result
- res_timeout  out  1  qualifies res_valid: 1 means core never answered
- frame_err  out  1  one-cycle pulse: malformed frame discarded
- busy  out  1  high in any state other than IDLE

Behaviour:
- Storage: N = IMG_W*IMG_H entries per bank, two banks, single write and read port each.
- Reset: all flags and counters clear; both banks empty; state RECOVER with counter = RST_CYC.
- Output reset values: s_ready=0, pix_out=0, pix_valid=0, core_rst_n=0, wb_load=0, res_valid=0, res_decision=0, res_timeout=0, frame_err=0, busy=1.
- Write side:
  - s_ready = !full[wbank], registered-free.
  - A beat is accepted when s_valid && s_ready. It writes s_data to wbank[wcnt], then wcnt++.
  - Accepted beat with wcnt==N-1 and s_last=1: set full[wbank], toggle wbank, wcnt=0.
  - Accepted beat with s_last=1 and wcnt<N-1, or wcnt==N-1 and s_last=0: frame_err pulse next cycle, wcnt=0, bank not marked full (frame discarded).
- Read side FSM:
  - IDLE: core_rst_n=0. If full[rbank] -> RELEASE.
  - RELEASE (1 cycle): core_rst_n=1 -> LOADWB.
  - LOADWB (1 cycle): wb_load=1 -> WBWAIT, cnt=WB_WAIT.
  - WBWAIT: decrement cnt; at 1 -> STREAM, rcnt=0.
  - STREAM: pix_valid=1, pix_out=rbank[rcnt]. The memory read is prefetched so pix_out is registered and gap-free for N consecutive cycles. After the Nth pixel: clear full[rbank], toggle rbank -> DRAIN, tcnt=TIMEOUT.
  - DRAIN: pix_out=0. If core_valid: res_decision=core_decision, res_timeout=0, res_valid pulse -> RECOVER. Else tcnt--; at 0: res_decision=4'hF, res_timeout=1, res_valid pulse -> RECOVER.
  - RECOVER: core_rst_n=0 for RST_CYC cycles -> IDLE.
- core_rst_n=1 only in RELEASE, LOADWB, WBWAIT, STREAM, DRAIN.
- A core_valid outside DRAIN is ignored.
- Latency: full[rbank] set in cycle T gives first pix_valid at T+3+WB_WAIT.
- Concurrency:
  - Write-complete on one bank and read-clear on the other in the same cycle are both honoured.
  - Writer and reader never address the same bank, because the writer is blocked on full.
  - Hosts may fill the second bank during STREAM/DRAIN, giving back-to-back frames without host stall beyond one frame.
- Reset mid-operation (rst_n low at any point): immediate return to reset values. Partially written or streamed frames are lost, and no res_valid is issued.
- Counters sized $clog2(N), $clog2(TIMEOUT+1); no wrap beyond the stated limits.

Test Plan:
- Single frame of pixels 0..255 repeating, s_last on beat 783 -> wb_load pulse, then 784 contiguous pix_valid cycles with matching raster data. Core model returns decision 4'd7 after 100 cycles -> res_valid, res_decision=7, res_timeout=0.
- Three back-to-back frames, s_valid always 1 -> s_ready drops only when both banks full. Results arrive in frame order. core_rst_n low RST_CYC cycles between frames.
- Frame with s_last on beat 500 -> frame_err pulse, no streaming. The next correct frame streams normally from pixel 0.
- Core model never asserts core_valid -> res_valid with res_timeout=1, res_decision=4'hF, exactly TIMEOUT+1 cycles after the last pixel.
- rst_n asserted at pixel 300 of STREAM -> all outputs at reset values asynchronously, s_ready returns after reset release, no stale res_valid.
- core_valid pulsed during STREAM, then decision 3 in DRAIN -> the STREAM pulse is ignored and res_decision=3.
